// File: rtl/hamming_secded_enc_stream.sv
// Streaming SECDED Hamming encoder with a 2-entry skid buffer, error injection
// and a saturating accepted-word counter.
module hamming_secded_enc_stream #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    // Smallest r with 2^r >= DATA_W + r + 1, closed form over the legal 4..64 range.
    localparam int P      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [CODE_W-1:0] inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]  word_cnt
);

    // Positions covered by the parity bit at 2^k, excluding that bit itself.
    function automatic logic [CODE_W-1:0] par_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if (((pos >> k) & 1) == 1 && pos != (1 << k))
                m = m | (CODE_W'(1) << pos);
        end
        return m;
    endfunction

    logic [CODE_W-1:0] dmap;
    logic [CODE_W-1:1] body;
    logic [CODE_W-1:0] enc;
    logic [CODE_W-1:0] stored;

    for (genvar pos = 0; pos < CODE_W; pos++) begin : g_map
        if (pos == 0 || (pos & (pos - 1)) == 0) begin : g_par_slot
            assign dmap[pos] = 1'b0;
        end else begin : g_data_slot
            // Data index = position minus the parity slots at or below it.
            assign dmap[pos] = in_data[pos - 1 - $clog2(pos + 1)];
        end
    end

    for (genvar pos = 1; pos < CODE_W; pos++) begin : g_body
        if ((pos & (pos - 1)) == 0) begin : g_parity
            assign body[pos] = ^(dmap & par_mask($clog2(pos)));
        end else begin : g_data
            assign body[pos] = dmap[pos];
        end
    end

    assign enc    = {body, ^body};
    assign stored = enc ^ (inj_en ? inj_mask : '0);

    logic              accept;
    logic              emit;
    logic              skid_valid;
    logic [CODE_W-1:0] skid_code;

    logic              out_valid_nxt;
    logic [CODE_W-1:0] out_code_nxt;
    logic              skid_valid_nxt;
    logic [CODE_W-1:0] skid_code_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        out_valid_nxt  = out_valid;
        out_code_nxt   = out_code;
        skid_valid_nxt = skid_valid;
        skid_code_nxt  = skid_code;
        cnt_nxt        = word_cnt;

        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
            cnt_nxt        = '0;
        end else begin
            if (accept && word_cnt != {CNT_W{1'b1}})
                cnt_nxt = word_cnt + CNT_W'(1);

            if (skid_valid) begin
                // in_ready is low here, so only a drain of SKID into OUT can happen.
                if (emit) begin
                    out_code_nxt   = skid_code;
                    skid_valid_nxt = 1'b0;
                end
            end else if (accept) begin
                if (!out_valid || emit) begin
                    out_valid_nxt = 1'b1;
                    out_code_nxt  = stored;
                end else begin
                    skid_valid_nxt = 1'b1;
                    skid_code_nxt  = stored;
                end
            end else if (emit) begin
                out_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the code registers are cleared too, so out_code reads zero in reset
            // and no stale codeword can reappear after release.
            out_valid  <= 1'b0;
            out_code   <= '0;
            skid_valid <= 1'b0;
            skid_code  <= '0;
            in_ready   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid  <= out_valid_nxt;
            out_code   <= out_code_nxt;
            skid_valid <= skid_valid_nxt;
            skid_code  <= skid_code_nxt;
            in_ready   <= ~skid_valid_nxt;
            word_cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hamming_secded_enc_stream.sv
// Directed bench for hamming_secded_enc_stream: 4-bit vectors, backpressure, counter,
// flush and async reset, plus 26/64-bit streams checked by a reference encoder.
module tb_hamming_secded_enc_stream;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: bit-by-bit construction with shifts.
    function automatic logic [71:0] ref_enc(input logic [63:0] d, input int dw);
        int p, cw, idx;
        logic [71:0] c, u;
        logic [63:0] t;
        logic x;
        p = 0;
        while ((1 << p) < dw + p + 1) p++;
        cw = dw + p + 1;
        c = '0;
        idx = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                t = d >> idx;
                if (t[0]) c = c | (72'(1) << pos);
                idx++;
            end
        end
        for (int k = 0; k < p; k++) begin
            x = 1'b0;
            for (int pos = 1; pos < cw; pos++) begin
                if (((pos >> k) & 1) == 1) begin
                    u = c >> pos;
                    x = x ^ u[0];
                end
            end
            if (x) c = c | (72'(1) << (1 << k));
        end
        if (^c) c = c | 72'(1);
        return c;
    endfunction

    function automatic int syndrome(input logic [71:0] c, input int cw);
        int s;
        logic [71:0] t;
        s = 0;
        for (int i = 1; i < cw; i++) begin
            t = c >> i;
            if (t[0]) s = s ^ i;
        end
        return s;
    endfunction

    // DUT a: DATA_W=4, CNT_W=4
    logic       a_rst, a_flush, a_in_valid, a_in_ready, a_inj_en, a_out_valid, a_out_ready;
    logic [3:0] a_in_data, a_word_cnt;
    logic [7:0] a_inj_mask, a_out_code;

    hamming_secded_enc_stream #(.DATA_W(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .inj_en(a_inj_en), .inj_mask(a_inj_mask),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_code(a_out_code),
        .word_cnt(a_word_cnt)
    );

    // DUT b: DATA_W=26 (CODE_W 32); DUT c: DATA_W=64 (CODE_W 72)
    logic        w_rst, w_flush;
    logic        b_in_valid, b_in_ready, b_inj_en, b_out_valid, b_out_ready;
    logic [25:0] b_in_data;
    logic [31:0] b_inj_mask, b_out_code;
    logic [15:0] b_word_cnt;
    logic        c_in_valid, c_in_ready, c_inj_en, c_out_valid, c_out_ready;
    logic [63:0] c_in_data;
    logic [71:0] c_inj_mask, c_out_code;
    logic [15:0] c_word_cnt;

    hamming_secded_enc_stream #(.DATA_W(26)) dut_b (
        .clk(clk), .rst(w_rst), .flush(w_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .inj_en(b_inj_en), .inj_mask(b_inj_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_code(b_out_code),
        .word_cnt(b_word_cnt)
    );

    hamming_secded_enc_stream #(.DATA_W(64)) dut_c (
        .clk(clk), .rst(w_rst), .flush(w_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .inj_en(c_inj_en), .inj_mask(c_inj_mask),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_code(c_out_code),
        .word_cnt(c_word_cnt)
    );

    typedef struct {
        logic [71:0] code;
        logic [71:0] mask;
    } exp_t;

    exp_t bq[$];
    exp_t cq[$];

    // Present one word to dut a for one edge (caller ensures in_ready=1).
    task automatic a_push(input logic [3:0] d, input logic en, input logic [7:0] m);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_inj_en   = en;
        a_inj_mask = m;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_inj_en   = 1'b0;
        a_inj_mask = '0;
    endtask

    initial begin
        exp_t e;
        logic [71:0] r;
        bit b_flip_done, c_flip_done;
        b_flip_done = 0;
        c_flip_done = 0;

        a_rst = 1; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_inj_en = 0; a_inj_mask = '0; a_out_ready = 1;
        w_rst = 1; w_flush = 0;
        b_in_valid = 0; b_in_data = '0; b_inj_en = 0; b_inj_mask = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = '0; c_inj_en = 0; c_inj_mask = '0; c_out_ready = 1;

        #3;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_code", a_out_code, 0);
        check("rst_word_cnt", a_word_cnt, 0);
        repeat (2) @(posedge clk);
        #1 a_rst = 0; w_rst = 0;
        @(posedge clk); #1;
        check("in_ready_after_rst", a_in_ready, 1);

        // single words, out_ready=1
        a_push(4'h0, 0, 8'h00); check("enc_0_valid", a_out_valid, 1); check("enc_0", a_out_code, 8'h00);
        a_push(4'h1, 0, 8'h00); check("enc_1", a_out_code, 8'h0F);
        a_push(4'hB, 0, 8'h00); check("enc_B", a_out_code, 8'hAA);
        a_push(4'hF, 0, 8'h00); check("enc_F", a_out_code, 8'hFF);
        check("cnt_4", a_word_cnt, 4);
        a_push(4'hB, 1, 8'h08); check("inj_single", a_out_code, 8'hA2);
        a_push(4'hB, 1, 8'h03); check("inj_double", a_out_code, 8'hA9);
        @(posedge clk); #1;
        check("drained_valid", a_out_valid, 0);

        // backpressure
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 4'h1;
        @(posedge clk); #1;
        check("bp_first_ready", a_in_ready, 1);
        a_in_data = 4'hF;
        @(posedge clk); #1;
        check("bp_ready_low", a_in_ready, 0);
        check("bp_hold_0F", a_out_code, 8'h0F);
        a_in_data = 4'hB;
        @(posedge clk); #1;
        check("bp_stable_code", a_out_code, 8'h0F);
        check("bp_stable_valid", a_out_valid, 1);
        check("bp_cnt_8", a_word_cnt, 8);
        a_out_ready = 1;
        @(posedge clk); #1;
        check("bp_out_FF", a_out_code, 8'hFF);
        check("bp_out_FF_valid", a_out_valid, 1);
        @(posedge clk); #1;
        check("bp_out_AA", a_out_code, 8'hAA);
        check("bp_out_AA_valid", a_out_valid, 1);
        a_in_valid = 0;
        @(posedge clk); #1;
        check("bp_done_valid", a_out_valid, 0);
        check("bp_cnt_9", a_word_cnt, 9);

        // counter saturation (CNT_W=4)
        for (int i = 0; i < 20; i++) begin
            a_push(4'(i), 0, 8'h00);
            if (i == 5) check("cnt_reach_F", a_word_cnt, 4'hF);
        end
        check("cnt_sat_F", a_word_cnt, 4'hF);
        a_out_ready = 0;
        a_push(4'h3, 0, 8'h00);
        check("pre_flush_valid", a_out_valid, 1);
        a_flush = 1; a_in_valid = 1; a_in_data = 4'h5;
        @(posedge clk); #1;
        a_flush = 0; a_in_valid = 0;
        check("flush_valid", a_out_valid, 0);
        check("flush_cnt", a_word_cnt, 0);
        check("flush_ready", a_in_ready, 1);

        // async reset between edges with both entries full
        a_push(4'h1, 0, 8'h00);
        a_push(4'hF, 0, 8'h00);
        check("pre_rst_skid_full", a_in_ready, 0);
        #3 a_rst = 1;
        #1;
        check("async_out_valid", a_out_valid, 0);
        check("async_out_code", a_out_code, 0);
        check("async_cnt", a_word_cnt, 0);
        #2 a_rst = 0;
        a_out_ready = 1;
        @(posedge clk); #1;
        check("post_rst_no_stale", a_out_valid, 0);
        check("post_rst_ready", a_in_ready, 1);
        a_push(4'hB, 0, 8'h00);
        check("post_rst_enc", a_out_code, 8'hAA);
        check("post_rst_cnt", a_word_cnt, 1);

        // wide directed vectors
        b_in_valid = 1; b_in_data = '1; c_in_valid = 1; c_in_data = '1;
        @(posedge clk); #1;
        check("b26_ones", b_out_code, 32'hFFFF_FFFF);
        check("c64_ones", c_out_code, {72{1'b1}});
        b_in_data = 26'h1; c_in_data = 64'h1;
        @(posedge clk); #1;
        b_in_valid = 0; c_in_valid = 0;
        check("b26_one", b_out_code, 32'h0000_000F);
        check("c64_one", c_out_code, 72'hF);
        @(posedge clk); #1;

        // random streams with random valid/ready and occasional injection
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = 26'($urandom);
            b_inj_en    = ($urandom_range(0, 7) == 0);
            b_inj_mask  = $urandom;
            b_out_ready = ($urandom_range(0, 3) != 0);
            c_in_valid  = 1'($urandom_range(0, 1));
            c_in_data   = {$urandom, $urandom};
            c_inj_en    = ($urandom_range(0, 7) == 0);
            c_inj_mask  = {8'($urandom), $urandom, $urandom};
            c_out_ready = ($urandom_range(0, 3) != 0);

            if (b_out_valid && b_out_ready) begin
                check("b26_pending", 72'(bq.size() != 0), 1);
                if (bq.size() != 0) begin
                    e = bq.pop_front();
                    check("b26_order", b_out_code, e.code ^ e.mask);
                    check("b26_syn_zero", 72'(syndrome(72'(b_out_code) ^ e.mask, 32)), 0);
                    if (!b_flip_done && e.mask == 0) begin
                        b_flip_done = 1;
                        for (int i = 1; i < 32; i++)
                            check("b26_flip_syn", 72'(syndrome(72'(b_out_code) ^ (72'(1) << i), 32)), 72'(i));
                    end
                end
            end
            if (b_in_valid && b_in_ready) begin
                r = ref_enc(64'(b_in_data), 26);
                bq.push_back('{code: r, mask: b_inj_en ? 72'(b_inj_mask) : 72'(0)});
            end

            if (c_out_valid && c_out_ready) begin
                check("c64_pending", 72'(cq.size() != 0), 1);
                if (cq.size() != 0) begin
                    e = cq.pop_front();
                    check("c64_order", c_out_code, e.code ^ e.mask);
                    check("c64_syn_zero", 72'(syndrome(c_out_code ^ e.mask, 72)), 0);
                    if (!c_flip_done && e.mask == 0) begin
                        c_flip_done = 1;
                        for (int i = 1; i < 72; i++)
                            check("c64_flip_syn", 72'(syndrome(c_out_code ^ (72'(1) << i), 72)), 72'(i));
                    end
                end
            end
            if (c_in_valid && c_in_ready) begin
                r = ref_enc(c_in_data, 64);
                cq.push_back('{code: r, mask: c_inj_en ? c_inj_mask : 72'(0)});
            end

            @(posedge clk); #1;
        end

        // bounded drain
        b_in_valid = 0; c_in_valid = 0; b_out_ready = 1; c_out_ready = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (b_out_valid && bq.size() != 0) begin
                e = bq.pop_front();
                check("b26_drain", b_out_code, e.code ^ e.mask);
            end
            if (c_out_valid && cq.size() != 0) begin
                e = cq.pop_front();
                check("c64_drain", c_out_code, e.code ^ e.mask);
            end
            @(posedge clk); #1;
        end
        check("b26_all_emitted", 72'(bq.size()), 0);
        check("c64_all_emitted", 72'(cq.size()), 0);
        check("b26_idle", b_out_valid, 0);
        check("c64_idle", c_out_valid, 0);
        check("b26_flip_done", 72'(b_flip_done), 1);
        check("c64_flip_done", 72'(c_flip_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
